// File: rtl/sram_like_req_arbiter_if.sv
// Sram-like bus bundle: the master drives the address phase, the slave returns the
// accept, response and read data.
interface sram_like_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_req_arbiter.sv
// Shares one sram-like slave between the inst and data masters; an in-order owner
// FIFO routes each response back. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module sram_like_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUTST  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  sram_like_req_arbiter_if.slave        inst,
  sram_like_req_arbiter_if.slave        data,
  sram_like_req_arbiter_if.master       mem,
  output logic                          err_spurious
);

  localparam int unsigned PtrW = $clog2(OUTST);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {OwnInst = 1'b0, OwnData = 1'b1} owner_e;

  logic [OUTST-1:0] tag_q;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             lock_q, lock_d;
  owner_e           lock_owner_q, lock_owner_d;
  logic             err_q, err_d;
  owner_e           grant;
  owner_e           head;
  logic             full, push, pop;
  logic [ADDR_W-1:0] granted_addr;
  logic [DATA_W-1:0] granted_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e rr_last_q, rr_last_d;
`endif

  assign full = (count_q == CntW'(OUTST));
  assign head = owner_e'(tag_q[rd_ptr_q]);

  always_comb begin
    if (lock_q) begin
      grant = lock_owner_q;
    end else if (inst.req && data.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (rr_last_q == OwnInst) ? OwnData : OwnInst;
`else
      grant = OwnData;
`endif
    end else if (data.req) begin
      grant = OwnData;
    end else begin
      grant = OwnInst;
    end
  end

  assign granted_addr  = (grant == OwnData) ? data.addr  : inst.addr;
  assign granted_wdata = (grant == OwnData) ? data.wdata : inst.wdata;

  // No bypass: a full FIFO blocks the grant even when a pop frees a slot this cycle.
  assign mem.req   = (inst.req | data.req) & ~full;
  assign mem.wr    = (grant == OwnData) ? data.wr   : inst.wr;
  assign mem.size  = (grant == OwnData) ? data.size : inst.size;
  assign mem.addr  = granted_addr;
  assign mem.wdata = granted_wdata;

  assign push = mem.req & mem.addr_ok;
  assign pop  = mem.data_ok & (count_q != '0);

  assign inst.addr_ok = push & (grant == OwnInst);
  assign data.addr_ok = push & (grant == OwnData);
  assign inst.data_ok = pop & (head == OwnInst);
  assign data.data_ok = pop & (head == OwnData);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;
  assign err_spurious = err_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CntW'(push) - CntW'(pop);
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    err_d        = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (mem.req && !mem.addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = grant;
    end else if (push) begin
      lock_d = 1'b0;
    end
    if (mem.data_ok && count_q == '0) err_d = 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  assign rr_last_d = push ? grant : rr_last_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= OwnInst;
      err_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q    <= OwnInst;
`endif
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  // Owner tags need no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_sram_like_req_arbiter.sv
// Bench for sram_like_req_arbiter: directed vector table, contention sequence and
// randomized traffic against a queue-based reference model.
module tb_sram_like_req_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif
  localparam int unsigned Outst = 4;
  localparam logic [31:0] Ia = 32'hBFC0_0000;
  localparam logic [31:0] Da = 32'h8000_1000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic err_spurious;

  sram_like_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  sram_like_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  sram_like_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  sram_like_req_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTST(Outst)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst         (inst_bus.slave),
    .data         (data_bus.slave),
    .mem          (mem_bus.master),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic rst_n, ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic e_mreq;
    logic [31:0] e_maddr;
    logic e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst_n, ireq, dreq, aok, dok, input logic [31:0] rdata,
                     input logic e_mreq, input logic [31:0] e_maddr,
                     input logic e_iaok, e_daok, e_idok, e_ddok, e_err);
    vec_t v;
    v.rst_n = rst_n; v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_iaok = e_iaok;
    v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst_n, ireq, dreq, aok, dok, input logic [31:0] rdata);
    resetn          = rst_n;
    inst_bus.req    = ireq;
    data_bus.req    = dreq;
    mem_bus.addr_ok = aok;
    mem_bus.data_ok = dok;
    mem_bus.rdata   = rdata;
  endtask

  // Reference model state: owner queue, lock, sticky error, last round-robin winner.
  bit   m_q[$];
  logic m_lock, m_lock_own, m_err, m_rr;

  task automatic model_reset();
    m_q.delete();
    m_lock = 0; m_lock_own = 0; m_err = 0; m_rr = 0;
  endtask

  // Pending-request bookkeeping for the randomized masters.
  logic        ip, dp;
  logic        e_iaok, e_daok;

  initial begin
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2; inst_bus.addr = Ia;
    inst_bus.wdata = 32'h0;
    data_bus.req = 0; data_bus.wr = 1; data_bus.size = 2; data_bus.addr = Da;
    data_bus.wdata = 32'hDEAD_BEEF;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;

    // Directed vectors: reset, single fetch, locked contention, full FIFO, spurious.
    row(1, 0, 0, 0, 0, 32'h0,         0, Ia, 0, 0, 0, 0, 0);
    row(1, 1, 0, 1, 0, 32'h0,         1, Ia, 1, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 32'h0,         0, Ia, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 1, 32'h3C08_BFAF, 0, Ia, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) row(1, 1, 1, 0, 0, 32'h0, 1, Da, 0, 0, 0, 0, 0);
    row(1, 1, 1, 1, 0, 32'h0,         1, Da, 0, 1, 0, 0, 0);
    row(1, 0, 0, 0, 1, 32'h1111_1111, 0, Ia, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      row(1, 1, 0, 1, 0, 32'h0,       1, Ia, 1, 0, 0, 0, 0);
      row(1, 0, 1, 1, 0, 32'h0,       1, Da, 0, 1, 0, 0, 0);
    end
    row(1, 1, 0, 1, 0, 32'h0,         0, Ia, 0, 0, 0, 0, 0);
    row(1, 0, 1, 1, 0, 32'h0,         0, Da, 0, 0, 0, 0, 0);
    row(1, 1, 0, 1, 1, 32'hAAAA_0001, 0, Ia, 0, 0, 1, 0, 0);
    row(1, 1, 0, 1, 0, 32'h0,         1, Ia, 1, 0, 0, 0, 0);
    row(1, 0, 0, 0, 1, 32'hAAAA_0002, 0, Ia, 0, 0, 0, 1, 0);
    row(1, 0, 0, 0, 1, 32'hAAAA_0003, 0, Ia, 0, 0, 1, 0, 0);
    row(1, 0, 0, 0, 1, 32'hAAAA_0004, 0, Ia, 0, 0, 0, 1, 0);
    row(1, 0, 0, 0, 1, 32'hAAAA_0005, 0, Ia, 0, 0, 1, 0, 0);
    row(1, 0, 0, 0, 1, 32'h5555_0000, 0, Ia, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 32'h0,         0, Ia, 0, 0, 0, 0, 1);
    row(1, 1, 0, 1, 0, 32'h0,         1, Ia, 1, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 32'h0000_0077, 0, Ia, 0, 0, 1, 0, 1);
    row(0, 0, 0, 0, 0, 32'h0,         0, Ia, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 32'h0,         0, Ia, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].ireq, tbl[i].dreq, tbl[i].aok, tbl[i].dok, tbl[i].rdata);
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i), 160'(mem_bus.req), 160'(tbl[i].e_mreq));
      chk($sformatf("row%0d mem_addr", i), 160'(mem_bus.addr), 160'(tbl[i].e_maddr));
      chk($sformatf("row%0d mem_wr", i), 160'(mem_bus.wr), 160'(tbl[i].e_maddr == Da));
      chk($sformatf("row%0d ok", i),
          160'({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}),
          160'({tbl[i].e_iaok, tbl[i].e_daok, tbl[i].e_idok, tbl[i].e_ddok}));
      chk($sformatf("row%0d rdata", i), 160'({inst_bus.rdata, data_bus.rdata}),
          160'({tbl[i].rdata, tbl[i].rdata}));
      chk($sformatf("row%0d err", i), 160'(err_spurious), 160'(tbl[i].e_err));
      @(posedge clk);
      #1;
    end

    // Continuous contention straight after reset, then drain in request order.
    begin
      logic exp_own [4];
      drive(0, 0, 0, 0, 0, 32'h0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        exp_own[i] = Rr ? ((i % 2) == 0) : 1'b1;
        drive(1, 1, 1, 1, 0, 32'h0);
        @(negedge clk);
        chk($sformatf("contend%0d addr_ok", i),
            160'({inst_bus.addr_ok, data_bus.addr_ok}), 160'({~exp_own[i], exp_own[i]}));
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        drive(1, 0, 0, 0, 1, 32'h0);
        @(negedge clk);
        chk($sformatf("drain%0d data_ok", i),
            160'({inst_bus.data_ok, data_bus.data_ok}), 160'({~exp_own[i], exp_own[i]}));
        @(posedge clk); #1;
      end
    end

    // Randomized traffic against the reference model.
    drive(0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    model_reset();
    ip = 0; dp = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        g, full, mreq, acc, pop, own, e_idok, e_ddok, rst_n, dok;
      logic [31:0] rd;
      logic [136:0] got, exp;
      rst_n = ($urandom_range(0, 199) != 0);
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; inst_bus.wr = 1'($urandom); inst_bus.size = 2'($urandom_range(0, 2));
        inst_bus.addr = $urandom; inst_bus.wdata = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; data_bus.wr = 1'($urandom); data_bus.size = 2'($urandom_range(0, 2));
        data_bus.addr = $urandom; data_bus.wdata = $urandom;
      end
      dok = (m_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 63) == 0);
      rd  = $urandom;
      drive(rst_n, ip, dp, 1'($urandom_range(0, 2) != 0), dok, rd);

      full = (m_q.size() == Outst);
      if (m_lock)        g = m_lock_own;
      else if (ip && dp) g = Rr ? ~m_rr : 1'b1;
      else               g = dp;
      mreq   = (ip | dp) & ~full;
      acc    = mreq & mem_bus.addr_ok;
      e_iaok = acc & ~g;
      e_daok = acc & g;
      pop    = dok && (m_q.size() > 0);
      own    = pop ? m_q[0] : 1'b0;
      e_idok = pop & ~own;
      e_ddok = pop & own;
      exp = {mreq, g ? data_bus.addr : inst_bus.addr, g ? data_bus.wr : inst_bus.wr,
             g ? data_bus.size : inst_bus.size, g ? data_bus.wdata : inst_bus.wdata,
             e_iaok, e_daok, e_idok, e_ddok, rd, rd, m_err};

      @(negedge clk);
      got = {mem_bus.req, mem_bus.addr, mem_bus.wr, mem_bus.size, mem_bus.wdata,
             inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok,
             inst_bus.rdata, data_bus.rdata, err_spurious};
      chk($sformatf("rand%0d", c), 160'(got), 160'(exp));

      if (!rst_n) begin
        model_reset();
        ip = 0; dp = 0;
      end else begin
        if (dok && m_q.size() == 0) m_err = 1;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
          m_q.push_back(g);
          m_rr = g;
        end
        if (mreq && !mem_bus.addr_ok) begin
          m_lock = 1; m_lock_own = g;
        end else if (acc) begin
          m_lock = 0;
        end
        if (e_iaok) ip = 0;
        if (e_daok) dp = 0;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
